// File: rtl/tdc_readout_pkg.sv
// -----------------------------------------------------------------------------
// tdc_readout_pkg
// Shared definitions for the CSM decoder-bank readout path: default TDC index
// width, word-counter width and the readout arbiter FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package tdc_readout_pkg;

  // Default width of a TDC index; 2**TDC_ID_W must cover the TDC count.
  localparam int TDC_ID_W = 4;

  // Width of the forwarded-word statistics counter.
  localparam int WORD_COUNT_W = 32;

  // Burst counter width; large enough for MAX_BURST up to 255.
  localparam int BURST_CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
// Combinational round-robin selector. Given a request vector and the index of
// the previously served requester, returns the first requesting index found
// when searching ptr+1, ptr+2, ... wrapping N-1 -> 0, with ptr itself last.
// Ports:
//   i_req    in  N    request vector
//   i_ptr    in  IDW  index of the last served requester (must be < N)
//   o_idx    out IDW  selected index (0 when nothing requests)
//   o_found  out 1    at least one request present
// -----------------------------------------------------------------------------
module rr_priority_select #(
  parameter int N   = 10,
  parameter int IDW = 4
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [IDW-1:0] o_idx,
  output logic           o_found
);

  int w_dist;
  int w_best_dist;

  // Each requester gets a distance from ptr: ptr+1 is 0, ptr itself is N-1.
  // The smallest distance wins, which is the wrapped search order.
  always_comb begin
    o_idx       = '0;
    o_found     = 1'b0;
    w_dist      = 0;
    w_best_dist = N;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - 1 - int'(i_ptr)) % N;
      if (i_req[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        o_idx       = IDW'(j);
        o_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_fifo_readout_arbiter.sv
// -----------------------------------------------------------------------------
// tdc_fifo_readout_arbiter
// Round-robin readout scheduler for the per-TDC matched-hit FIFOs of one CSM
// decoder bank. One non-empty, unmasked FIFO is granted at a time for a burst
// of at most MAX_BURST words; its words are popped and merged into a single
// registered valid/ready stream tagged with the TDC index.
// Ports:
//   sys_clk_160     in   1              system clock
//   rst_160         in   1              asynchronous active-high reset
//   enable          in   1              arbitration enable (low = no new pops)
//   tdc_mask        in   TDC_COUNT      1 = FIFO excluded from arbitration
//   tdc_fifo_empty  in   TDC_COUNT      per-FIFO empty flags
//   tdc_fifo_data   in   TDC_COUNT*W    FWFT data, FIFO j at [(j+1)*W-1:j*W]
//   tdc_fifo_read   out  TDC_COUNT      one-hot (or zero) pop strobe
//   out_data        out  W              merged word
//   out_tdc_id      out  ID_W           source FIFO of out_data
//   out_valid       out  1              out_data/out_tdc_id valid
//   out_ready       in   1              downstream accept
//   grant_active    out  1              high while a FIFO is granted
//   word_count      out  32             words forwarded since reset (wraps)
// -----------------------------------------------------------------------------
module tdc_fifo_readout_arbiter
  import tdc_readout_pkg::*;
#(
  parameter int TDC_COUNT      = 10,
  parameter int TDC_DATA_WIDTH = 40,
  parameter int MAX_BURST      = 4,
  parameter int ID_W           = TDC_ID_W
) (
  input  logic                                sys_clk_160,
  input  logic                                rst_160,
  input  logic                                enable,
  input  logic [TDC_COUNT-1:0]                tdc_mask,
  input  logic [TDC_COUNT-1:0]                tdc_fifo_empty,
  input  logic [TDC_COUNT*TDC_DATA_WIDTH-1:0] tdc_fifo_data,
  output logic [TDC_COUNT-1:0]                tdc_fifo_read,
  output logic [TDC_DATA_WIDTH-1:0]           out_data,
  output logic [ID_W-1:0]                     out_tdc_id,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                grant_active,
  output logic [WORD_COUNT_W-1:0]             word_count
);

  arb_state_e                r_state;
  logic [ID_W-1:0]           r_ptr;
  logic [ID_W-1:0]           r_grant;
  logic [BURST_CNT_W-1:0]    r_burst_cnt;
  logic [TDC_DATA_WIDTH-1:0] r_out_data;
  logic [ID_W-1:0]           r_out_tdc_id;
  logic                      r_out_valid;
  logic [WORD_COUNT_W-1:0]   r_word_count;

  logic [TDC_COUNT-1:0]      w_req;
  logic [ID_W-1:0]           w_sel_idx;
  logic                      w_sel_found;
  logic                      w_g_empty;
  logic                      w_g_mask;
  logic [TDC_DATA_WIDTH-1:0] w_g_data;
  logic                      w_slot_free;
  logic                      w_pop;
  logic                      w_burst_last;
  logic                      w_leave;

  assign w_req = ~tdc_fifo_empty & ~tdc_mask;

  rr_priority_select #(
    .N   (TDC_COUNT),
    .IDW (ID_W)
  ) u_rr_sel (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_sel_idx),
    .o_found (w_sel_found)
  );

  // Flags and data of the granted FIFO, selected with a compare loop so no
  // arithmetic on the grant index is needed.
  always_comb begin
    w_g_empty = 1'b1;
    w_g_mask  = 1'b1;
    w_g_data  = '0;
    for (int j = 0; j < TDC_COUNT; j++) begin
      if (r_grant == ID_W'(j)) begin
        w_g_empty = tdc_fifo_empty[j];
        w_g_mask  = tdc_mask[j];
        w_g_data  = tdc_fifo_data[j*TDC_DATA_WIDTH +: TDC_DATA_WIDTH];
      end
    end
  end

  // The output register can take a new word when empty or being drained.
  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_pop        = (r_state == ST_GRANT) && w_slot_free && !w_g_empty &&
                        !w_g_mask && enable;
  assign w_burst_last = (r_burst_cnt == BURST_CNT_W'(MAX_BURST - 1));
  // Losing the request (empty, masked, disabled) ends the grant immediately;
  // a stalled but still-requesting FIFO keeps its grant.
  assign w_leave      = (w_pop && w_burst_last) || w_g_empty || w_g_mask || !enable;

  // Pop strobe is combinational so the FWFT FIFO advances in the same cycle
  // the word is captured.
  always_comb begin
    tdc_fifo_read = '0;
    for (int j = 0; j < TDC_COUNT; j++) begin
      if (w_pop && (r_grant == ID_W'(j))) begin
        tdc_fifo_read[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk_160 or posedge rst_160) begin
    if (rst_160) begin
      r_state      <= ST_IDLE;
      // Starting at the last index makes the first search begin at FIFO 0.
      r_ptr        <= ID_W'(TDC_COUNT - 1);
      r_grant      <= '0;
      r_burst_cnt  <= '0;
      r_out_data   <= '0;
      r_out_tdc_id <= '0;
      r_out_valid  <= 1'b0;
      r_word_count <= '0;
    end else begin
      // Output register: load on pop, otherwise retire a consumed word.
      if (w_pop) begin
        r_out_data   <= w_g_data;
        r_out_tdc_id <= r_grant;
        r_out_valid  <= 1'b1;
        r_word_count <= r_word_count + 1'b1;
      end else if (w_slot_free) begin
        r_out_valid  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (enable && w_sel_found) begin
            r_grant     <= w_sel_idx;
            r_burst_cnt <= '0;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_pop) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
          if (w_leave) begin
            r_ptr   <= r_grant;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_data     = r_out_data;
  assign out_tdc_id   = r_out_tdc_id;
  assign out_valid    = r_out_valid;
  assign grant_active = (r_state == ST_GRANT);
  assign word_count   = r_word_count;

`ifndef SYNTHESIS
  a_read_onehot0 : assert property (@(posedge sys_clk_160) disable iff (rst_160)
    $onehot0(tdc_fifo_read));
  a_hold_on_stall : assert property (@(posedge sys_clk_160) disable iff (rst_160)
    (r_out_valid && !out_ready) |=> $stable(r_out_data) && $stable(r_out_tdc_id));
`endif

endmodule

// File: tb/tb_tdc_fifo_readout_arbiter.sv
module tb_tdc_fifo_readout_arbiter;

  localparam int N  = 10;
  localparam int W  = 40;
  localparam int MB = 4;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   id;
  } sb_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [N-1:0]   tdc_mask;
  logic [N-1:0]   tdc_fifo_empty;
  logic [N*W-1:0] tdc_fifo_data;
  logic [N-1:0]   tdc_fifo_read;
  logic [W-1:0]   out_data;
  logic [3:0]     out_tdc_id;
  logic           out_valid;
  logic           out_ready;
  logic           grant_active;
  logic [31:0]    word_count;

  logic [W-1:0]   fq [N][$];
  sb_t            sb [$];
  logic [N-1:0]   last_rd;
  int             pop_cnt [N];
  int             n_checks = 0;
  int             n_pass   = 0;

  always #5 clk = ~clk;

  tdc_fifo_readout_arbiter #(
    .TDC_COUNT      (N),
    .TDC_DATA_WIDTH (W),
    .MAX_BURST      (MB),
    .ID_W           (4)
  ) dut (
    .sys_clk_160    (clk),
    .rst_160        (rst),
    .enable         (enable),
    .tdc_mask       (tdc_mask),
    .tdc_fifo_empty (tdc_fifo_empty),
    .tdc_fifo_data  (tdc_fifo_data),
    .tdc_fifo_read  (tdc_fifo_read),
    .out_data       (out_data),
    .out_tdc_id     (out_tdc_id),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .grant_active   (grant_active),
    .word_count     (word_count)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic refresh();
    for (int j = 0; j < N; j++) begin
      tdc_fifo_empty[j] = (fq[j].size() == 0);
      tdc_fifo_data[j*W +: W] = (fq[j].size() != 0) ? fq[j][0] : '0;
    end
  endtask

  function automatic logic [W-1:0] mkword(int f, int s);
    logic [23:0] r;
    r = 24'($urandom);
    return {8'(f), 8'(s), r};
  endfunction

  task automatic push_word(int f, logic [W-1:0] w, bit expect_out);
    fq[f].push_back(w);
    if (expect_out) sb.push_back('{data: w, id: 4'(f)});
    refresh();
  endtask

  // One clock: sample before the edge, model FIFO pops after it, scoreboard
  // accepted words. Enters and returns just after a falling edge.
  task automatic cycle();
    logic [N-1:0] rd;
    logic         acc;
    logic [W-1:0] d;
    logic [3:0]   id;
    sb_t          e;
    #1;
    rd  = tdc_fifo_read;
    acc = out_valid && out_ready;
    d   = out_data;
    id  = out_tdc_id;
    n_checks++;
    if ($countones(rd) > 1) $display("FAIL read_onehot read=%b required at most one bit", rd);
    else n_pass++;
    if (acc) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_word got id=%0d data=%h required no word", id, d);
      end else begin
        e = sb.pop_front();
        if (d !== e.data || id !== e.id)
          $display("FAIL sb_word got id=%0d data=%h required id=%0d data=%h", id, d, e.id, e.data);
        else n_pass++;
      end
    end
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) begin
      if (rd[j]) begin
        pop_cnt[j]++;
        n_checks++;
        if (fq[j].size() == 0) $display("FAIL underflow fifo=%0d popped while empty", j);
        else begin
          void'(fq[j].pop_front());
          n_pass++;
        end
      end
    end
    refresh();
    last_rd = rd;
    @(negedge clk);
  endtask

  task automatic drain(int budget, string tag);
    int k = 0;
    while ((sb.size() != 0 || out_valid) && k < budget) begin
      cycle();
      k++;
    end
    n_checks++;
    if (sb.size() != 0 || out_valid)
      $display("FAIL drain_%s timeout pending=%0d required 0", tag, sb.size());
    else n_pass++;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; tdc_mask = '0; out_ready = 1'b1; last_rd = '0;
    for (int j = 0; j < N; j++) pop_cnt[j] = 0;
    refresh();
    @(negedge clk);
    #1;
    n_checks++;
    if (tdc_fifo_read !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_tdc_id !== '0 ||
        grant_active !== 1'b0 || word_count !== 32'd0)
      $display("FAIL reset_values read=%b valid=%b data=%h id=%0d grant=%b wc=%0d required all 0",
               tdc_fifo_read, out_valid, out_data, out_tdc_id, grant_active, word_count);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks++;
      if (last_rd !== '0 || out_valid !== 1'b0 || word_count !== 32'd0 || grant_active !== 1'b0)
        $display("FAIL idle_empty read=%b valid=%b wc=%0d grant=%b required 0/0/0/0",
                 last_rd, out_valid, word_count, grant_active);
      else n_pass++;
    end
  endtask

  task automatic test_single_fifo_bursts();
    int runs[$];
    int gaps[$];
    int exp_runs[3] = '{4, 4, 2};
    bit in_run = 0;
    int cur = 0;
    int gap = 0;
    int k = 0;
    for (int s = 0; s < 10; s++) push_word(3, mkword(3, s), 1'b1);
    while (k < 80 && (sb.size() != 0 || out_valid || fq[3].size() != 0 || in_run)) begin
      cycle();
      k++;
      if (last_rd[3]) begin
        if (!in_run && runs.size() > 0) gaps.push_back(gap);
        if (!in_run) cur = 0;
        in_run = 1;
        cur++;
      end else begin
        if (in_run) begin
          runs.push_back(cur);
          gap = 0;
        end
        in_run = 0;
        gap++;
      end
    end
    n_checks++;
    if (runs.size() != 3) $display("FAIL burst_count got %0d bursts required 3", runs.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < runs.size(); i++) begin
      n_checks++;
      if (runs[i] != exp_runs[i]) $display("FAIL burst_len[%0d] got %0d required %0d", i, runs[i], exp_runs[i]);
      else n_pass++;
    end
    for (int i = 0; i < gaps.size(); i++) begin
      n_checks++;
      if (gaps[i] != 1) $display("FAIL burst_gap[%0d] got %0d idle cycles required 1", i, gaps[i]);
      else n_pass++;
    end
    n_checks++;
    if (sb.size() != 0 || word_count !== 32'd10)
      $display("FAIL single_wc got wc=%0d pending=%0d required wc=10 pending=0", word_count, sb.size());
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int fl[3] = '{0, 5, 9};
    logic [W-1:0] words [3][8];
    pulse_reset();
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 8; s++) begin
        words[f][s] = mkword(fl[f], s);
        push_word(fl[f], words[f][s], 1'b0);
      end
    for (int r = 0; r < 2; r++)
      for (int f = 0; f < 3; f++)
        for (int s = 0; s < 4; s++)
          sb.push_back('{data: words[f][r*4+s], id: 4'(fl[f])});
    drain(200, "rr");
    n_checks++;
    if (word_count !== 32'd24) $display("FAIL rr_wc got %0d required 24", word_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] cap_d;
    logic [3:0]   cap_id;
    int k = 0;
    for (int s = 0; s < 8; s++) push_word(2, mkword(2, s), 1'b1);
    while (!out_valid && k < 20) begin cycle(); k++; end
    n_checks++;
    if (!out_valid) $display("FAIL bp_start out_valid=%b required 1", out_valid);
    else n_pass++;
    out_ready = 1'b0;
    cap_d  = out_data;
    cap_id = out_tdc_id;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_checks++;
      if (last_rd !== '0 || out_valid !== 1'b1 || out_data !== cap_d || out_tdc_id !== cap_id)
        $display("FAIL bp_hold read=%b valid=%b data=%h id=%0d required 0/1/%h/%0d",
                 last_rd, out_valid, out_data, out_tdc_id, cap_d, cap_id);
      else n_pass++;
    end
    out_ready = 1'b1;
    drain(100, "bp");
    n_checks++;
    if (word_count !== 32'd32) $display("FAIL bp_wc got %0d required 32", word_count);
    else n_pass++;
  endtask

  task automatic test_mask();
    int base;
    int k = 0;
    tdc_mask = 10'b00_0010_0000;
    for (int s = 0; s < 8; s++) push_word(5, mkword(5, s), 1'b0);
    for (int s = 0; s < 3; s++) push_word(1, mkword(1, s), 1'b1);
    for (int i = 0; i < 30; i++) begin
      cycle();
      n_checks++;
      if (last_rd[5]) $display("FAIL mask_static fifo 5 read=1 required 0");
      else n_pass++;
    end
    n_checks++;
    if (sb.size() != 0 || fq[5].size() != 8)
      $display("FAIL mask_static_state pending=%0d fifo5=%0d required 0 and 8", sb.size(), fq[5].size());
    else n_pass++;
    for (int s = 0; s < 8; s++) sb.push_back('{data: fq[5][s], id: 4'd5});
    tdc_mask = '0;
    base = pop_cnt[5];
    while (pop_cnt[5] < base + 2 && k < 30) begin cycle(); k++; end
    tdc_mask = 10'b00_0010_0000;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_checks++;
      if (last_rd[5]) $display("FAIL mask_mid fifo 5 read=1 required 0");
      else n_pass++;
    end
    n_checks++;
    if (fq[5].size() != 6 || grant_active !== 1'b0)
      $display("FAIL mask_mid_state fifo5=%0d grant=%b required 6 and 0", fq[5].size(), grant_active);
    else n_pass++;
    tdc_mask = '0;
    drain(100, "mask");
    n_checks++;
    if (word_count !== 32'd43) $display("FAIL mask_wc got %0d required 43", word_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] w4 [8];
    logic [W-1:0] w0 [2];
    int k = 0;
    for (int s = 0; s < 8; s++) begin
      w4[s] = mkword(4, s);
      push_word(4, w4[s], 1'b1);
    end
    while (!out_valid && k < 20) begin cycle(); k++; end
    n_checks++;
    if (!out_valid || fq[4].size() != 7)
      $display("FAIL ar_start valid=%b fifo4=%0d required 1 and 7", out_valid, fq[4].size());
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (tdc_fifo_read !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_tdc_id !== '0 ||
        grant_active !== 1'b0 || word_count !== 32'd0)
      $display("FAIL async_reset read=%b valid=%b data=%h id=%0d grant=%b wc=%0d required all 0",
               tdc_fifo_read, out_valid, out_data, out_tdc_id, grant_active, word_count);
    else n_pass++;
    sb.delete();
    for (int s = 0; s < 2; s++) begin
      w0[s] = mkword(0, s);
      push_word(0, w0[s], 1'b1);
    end
    for (int s = 1; s < 8; s++) sb.push_back('{data: w4[s], id: 4'd4});
    cycle();
    rst = 1'b0;
    k = 0;
    while (last_rd == '0 && k < 10) begin cycle(); k++; end
    n_checks++;
    if (last_rd !== 10'b00_0000_0001) $display("FAIL first_grant read=%b required 0000000001", last_rd);
    else n_pass++;
    drain(100, "ar");
    n_checks++;
    if (word_count !== 32'd9) $display("FAIL ar_wc got %0d required 9", word_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_fifo_bursts();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
